// File: rtl/comm_defs_pkg.sv
// Shared definitions for the UART transmit path: launch FSM states
// and the software flow-control characters decoded by the RX side.
package comm_defs_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } txq_state_e;

    localparam logic [7:0] XON  = 8'h11;
    localparam logic [7:0] XOFF = 8'h13;

    // Busy-timeout counter width; covers timeouts up to 15 cycles.
    localparam int TMO_W = 4;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, flush and occupancy level.
// Flush discards buffered entries but honours a same-cycle pop.
module uart_sync_fifo
    import comm_defs_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign level_o = wr_q - rd_q;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        rd_d = rd_q + {{AW{1'b0}}, pop_ok};
        wr_d = wr_q + {{AW{1'b0}}, push_ok};
        if (flush_i) begin
            wr_d = rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset; only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and launch sequencer feeding the UART transmitter.
// Define UART_TXQ_XON_EN to add the xoff pause input.
module uart_tx_queue
    import comm_defs_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int AW           = $clog2(DEPTH),
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        flush,
    output logic        txen,
    output logic [7:0]  tx_byte,
    input  logic        tx_ing,
    output logic [AW:0] level,
`ifdef UART_TXQ_XON_EN
    input  logic        xoff,
`endif
    output logic        launch_err,
    output logic        launch_err_sticky
);

    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(BUSY_TIMEOUT);

    txq_state_e       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       byte_q, byte_d;
    logic             sticky_q, sticky_d;
    logic             pop;
    logic             err;
    logic             pause;
    logic             full;
    logic             empty;
    logic [7:0]       head;

`ifdef UART_TXQ_XON_EN
    assign pause = xoff;
`else
    assign pause = 1'b0;
`endif

    assign in_ready = !full;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (in_data),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        byte_d  = byte_q;
        pop     = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && !tx_ing && !pause) begin
                    byte_d  = head;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                tmo_d   = TMO_LOAD;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // The FIFO ignores this pop if a flush already emptied it.
                if (tx_ing) begin
                    pop     = 1'b1;
                    state_d = WAIT_DONE;
                end else if (tmo_q == '0) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_ing) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sticky_d = sticky_q;
        if (flush) begin
            sticky_d = 1'b0;
        end
        if (err) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            byte_q   <= 8'h00;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            byte_q   <= byte_d;
            sticky_q <= sticky_d;
        end
    end

    assign txen              = (state_q == LAUNCH);
    assign tx_byte           = byte_q;
    assign launch_err        = err;
    assign launch_err_sticky = sticky_q;

endmodule
